mem_dma_reader: RTL and testbench
=================================

Name: mem_dma_reader

Overview:
- Read-side initiator for the single-clock simple-dual-port RAM.
- On a start pulse, it fetches LEN consecutive words beginning at BASE. It drives the RAM read-address and read-enable pins and absorbs the RAM's fixed read latency.
- It presents the words as a valid/ready stream with a last flag, for display-list and line-buffer consumers.
- Credit-based issue means RAM data is never dropped under consumer back-pressure.

Parameters:
- DATA_W, 8, RAM word width (NB_COL*COL_WIDTH of the RAM).
- RAM_DEPTH, 2048, RAM entries. ADDR_W = clogb2(RAM_DEPTH-1), which is 11 at the default.
- READ_LATENCY, 1, RAM read latency in clocks. 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE. Other values are illegal (elaboration $error).
- FIFO_DEPTH, 4, output buffer entries. Must be ≥ READ_LATENCY+2 (elaboration $error otherwise).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base  in  ADDR_W  first word address; sampled with start.
- len  in  ADDR_W+1  word count, 0..RAM_DEPTH; sampled with start.
- ram_addr_r  out  ADDR_W  RAM read address (addrR).
- ram_en_r  out  1  RAM read enable (enR).
- ram_dout  in  DATA_W  RAM read data (Dout).
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_last  out  1  marks the final word of the transfer.
- out_ready  in  1  consumer accept.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0. FIFO empty, in-flight shift register cleared, state IDLE.
- Reset asserted mid-transfer aborts immediately. In-flight RAM reads are discarded and no done pulse is produced.

State machine (IDLE, RUN, DRAIN, DONE):
- IDLE → RUN on start with len≠0. Latch addr=base, issue_rem=len, pop_rem=len.
- IDLE → DONE on start with len==0. No RAM access occurs.
- start is ignored outside IDLE.
- RUN → DRAIN in the cycle the last read is issued (issue_rem reaches 0).
- DRAIN → DONE in the cycle the last word is popped (out_valid&out_ready&out_last).
- DONE → IDLE unconditionally after one cycle.
- busy = (state≠IDLE) && (state≠DONE). done = (state==DONE).

Read issue:
- ram_en_r = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH). This is combinational, from registers only.
- ram_addr_r = addr register.
- On each issue, addr increments modulo RAM_DEPTH (RAM_DEPTH-1 wraps to 0) and issue_rem decrements.

Latency tracking and output:
- A READ_LATENCY-deep valid shift register marks the cycle in which ram_dout holds issued data. That word is written into the FIFO at the next edge.
- The credit check ignores a same-cycle pop (conservative). Simultaneous FIFO push and pop is legal and keeps the count unchanged.
- out_valid = FIFO non-empty. out_data and out_last come from the FIFO head. The FIFO output is not combinationally dependent on out_ready.
- out_last is stored with the word whose pop_rem is 1. pop_rem decrements on each accepted word.
- First out_valid rises READ_LATENCY+1 clocks after the edge that samples start.
- With out_ready held high, throughput is 1 word/clock after the fill latency.
- Stream data is held stable while out_valid && !out_ready.

Optional Feature:
- Macro MEM_DMA_READER_CHECKSUM_EN.
- With the macro defined, an extra output port csum (DATA_W) carries the running XOR of every accepted word in the current transfer:
  - cleared on start;
  - updated on each out_valid&out_ready;
  - holds its value through DONE and IDLE until the next start;
  - reset value 0.
- Without the macro, the port and its logic are absent.

Decomposition:
- Package mem_pkg holds:
  - the clogb2 function;
  - the state enum typedef (IDLE, RUN, DRAIN, DONE);
  - the legal READ_LATENCY values.
- One sub-module, mem_dma_rd_fifo: a synchronous FIFO of width DATA_W+1 carrying data and last. It exposes push, pop, count, empty, full, and uses the same clk/rst_n.

Test Plan:
- RAM preloaded with addr&0xFF, READ_LATENCY=1; start base=0x010 len=4, out_ready=1 → 0x10..0x13 on consecutive clocks, out_last on 0x13, done one clock after the last accept, busy low afterwards.
- Same transfer with READ_LATENCY=2 → first out_valid 3 clocks after the start edge (1 clock later than the L=1 case), 1 word/clock thereafter.
- start base=0x7FE len=4 → words 0x7FE, 0x7FF, 0x000, 0x001 in that order (wrap).
- len=0 → no ram_en_r ever, done pulses 1 clock after start, out_valid stays 0.
- len=16 with out_ready toggling at random (50%) → all 16 words delivered in order, none dropped or duplicated, fifo_count never exceeds FIFO_DEPTH, data held stable while stalled. A second start pulse mid-transfer is ignored.
- rst_n low mid-transfer at word 5 of 10 → all outputs 0 asynchronously, no done pulse. After release, a new start base=0 len=2 delivers exactly 2 fresh words. With MEM_DMA_READER_CHECKSUM_EN, words 0x01, 0x02, 0x04 give csum=0x07.

Source files
------------

// File: rtl/mem_dma_reader_pkg.sv
// Shared types and helpers for the RAM read-side DMA initiator.
// Provides clogb2, the FSM state type and the legal RAM read latencies.
package mem_pkg;

    function automatic int clogb2(input int v);
        int r;
        r = 0;
        for (int x = v; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int LAT_LOW  = 1;
    localparam int LAT_HIGH = 2;

    function automatic bit lat_legal(input int l);
        return (l == LAT_LOW) || (l == LAT_HIGH);
    endfunction

endpackage

// File: rtl/mem_dma_reader_if.sv
// RAM read pins plus the valid/ready output stream of the DMA reader.
// master = reader side, slave = RAM/consumer side.
interface mem_dma_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] ram_addr_r;
    logic              ram_en_r;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport master (
        output ram_addr_r, ram_en_r,
        input  ram_dout,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  ram_addr_r, ram_en_r,
        output ram_dout,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_dma_rd_fifo.sv
// Small synchronous FIFO holding {last, data} words for the reader.
// Push when full / pop when empty are ignored.
module mem_dma_rd_fifo
    import mem_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    localparam int CNT_W = clogb2(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? clogb2(DEPTH - 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= inc(wr_ptr);
            if (rd_en) rd_ptr <= inc(rd_ptr);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mem_dma_reader.sv
// Fetches len words from base out of a fixed-latency RAM into a stream.
// Optional running-XOR output csum: define MEM_DMA_READER_CHECKSUM_EN.
module mem_dma_reader
    import mem_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int RAM_DEPTH    = 2048,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4,
    localparam int ADDR_W = clogb2(RAM_DEPTH - 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    mem_dma_reader_if.master  bus,
    output logic              busy,
    output logic              done
`ifdef MEM_DMA_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);
    localparam int CNT_W = clogb2(FIFO_DEPTH);
    localparam int FW    = DATA_W + 1;

    if (!lat_legal(READ_LATENCY)) begin : g_lat_chk
        $error("mem_dma_reader: READ_LATENCY must be 1 or 2");
    end
    if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_fifo_chk
        $error("mem_dma_reader: FIFO_DEPTH must be >= READ_LATENCY+2");
    end

    state_t               state;
    logic [ADDR_W-1:0]    addr;
    logic [ADDR_W:0]      issue_rem;
    logic [ADDR_W:0]      pop_rem;
    logic [READ_LATENCY-1:0] vld_sr;
    logic [READ_LATENCY-1:0] last_sr;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [FW-1:0]        fifo_dout;
    logic [CNT_W:0]       inflight;
    logic [CNT_W:0]       occ;
    logic                 issue;
    logic                 accept;
    logic [ADDR_W-1:0]    addr_nxt;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + (CNT_W + 1)'(vld_sr[i]);
        end
    end

    // Credit counts reads still in the RAM pipe, so every issue has a slot.
    assign occ    = (CNT_W + 1)'(fifo_count) + inflight;
    assign issue  = (state == RUN) && !fifo_full
                    && (occ < (CNT_W + 1)'(FIFO_DEPTH));
    assign accept = bus.out_valid && bus.out_ready;
    assign addr_nxt = (addr == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr + 1'b1;

    assign bus.ram_en_r   = issue;
    assign bus.ram_addr_r = addr;
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = fifo_dout[DATA_W-1:0] & {DATA_W{!fifo_empty}};
    assign bus.out_last   = fifo_dout[DATA_W] & !fifo_empty;
    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            vld_sr[0]  <= issue;
            last_sr[0] <= issue && (issue_rem == (ADDR_W + 1)'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            issue_rem <= '0;
            pop_rem   <= '0;
        end else begin
            if (accept) pop_rem <= pop_rem - 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base;
                        issue_rem <= len;
                        pop_rem   <= len;
                        state     <= (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr      <= addr_nxt;
                        issue_rem <= issue_rem - 1'b1;
                        if (issue_rem == (ADDR_W + 1)'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept && pop_rem == (ADDR_W + 1)'(1)) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_dma_rd_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_sr[READ_LATENCY-1]),
        .din   ({last_sr[READ_LATENCY-1], bus.ram_dout}),
        .pop   (accept),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef MEM_DMA_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == IDLE && start) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum ^ bus.out_data;
        end
    end
`endif
endmodule

// File: tb/tb_mem_dma_reader.sv
// Scoreboard bench: one reader at read latency 1, one at latency 2,
// both fed identical commands from their own behavioural RAMs.
module tb_mem_dma_reader;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [10:0] base = '0;
    logic [11:0] len = '0;
    logic        rdy = 1;
    logic        busy1, done1, busy2, done2;
`ifdef MEM_DMA_READER_CHECKSUM_EN
    logic [7:0]  csum1, csum2;
`endif

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] ram [2048];
    logic [7:0] st2;
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    bit         stall [2];
    logic [7:0] pd [2];
    logic       pl [2];
    int         acc_cnt [2];
    int         last_acc [2];

    mem_dma_reader_if #(.DATA_W(8), .ADDR_W(11)) bus1 ();
    mem_dma_reader_if #(.DATA_W(8), .ADDR_W(11)) bus2 ();

    assign bus1.out_ready = rdy;
    assign bus2.out_ready = rdy;

    mem_dma_reader #(.READ_LATENCY(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .base  (base),
        .len   (len),
        .bus   (bus1),
        .busy  (busy1),
        .done  (done1)
`ifdef MEM_DMA_READER_CHECKSUM_EN
        ,
        .csum  (csum1)
`endif
    );

    mem_dma_reader #(.READ_LATENCY(2)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .base  (base),
        .len   (len),
        .bus   (bus2),
        .busy  (busy2),
        .done  (done2)
`ifdef MEM_DMA_READER_CHECKSUM_EN
        ,
        .csum  (csum2)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAMs: latency 1 and latency 2 (always-enabled output reg).
    always @(posedge clk) begin
        if (bus1.ram_en_r) bus1.ram_dout <= ram[bus1.ram_addr_r];
        if (bus2.ram_en_r) st2 <= ram[bus2.ram_addr_r];
        bus2.ram_dout <= st2;
    end

    function automatic logic [7:0] exp_word(input int a);
        if (a == 'h100) return 8'h01;
        if (a == 'h101) return 8'h02;
        if (a == 'h102) return 8'h04;
        return 8'(a & 'hFF);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_step(input int id, input logic v, input logic r,
                            input logic [7:0] d, input logic l);
        logic [8:0] e;
        int         sz;
        if (stall[id]) begin
            check($sformatf("hold%0d", id), {v, l, d}, {1'b1, pl[id], pd[id]});
        end
        if (v && r) begin
            sz = (id == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                check($sformatf("extra_word%0d", id), {l, d}, 'h1FF);
            end else begin
                if (id == 0) e = q0.pop_front();
                else e = q1.pop_front();
                check($sformatf("word%0d", id), {l, d}, e);
                acc_cnt[id]++;
                if (l) last_acc[id] = cyc;
            end
        end
        stall[id] = v && !r;
        pd[id] = d;
        pl[id] = l;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_step(0, bus1.out_valid, bus1.out_ready, bus1.out_data,
                     bus1.out_last);
            mon_step(1, bus2.out_valid, bus2.out_ready, bus2.out_data,
                     bus2.out_last);
        end else begin
            stall[0] = 0;
            stall[1] = 0;
        end
    end

    task automatic push_exp(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            q0.push_back({i == l - 1, exp_word((b + i) % 2048)});
            q1.push_back({i == l - 1, exp_word((b + i) % 2048)});
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_o1"}, {bus1.ram_addr_r, bus1.ram_en_r, bus1.out_data,
              bus1.out_valid, bus1.out_last, busy1, done1}, 0);
        check({tag, "_o2"}, {bus2.ram_addr_r, bus2.ram_en_r, bus2.out_data,
              bus2.out_valid, bus2.out_last, busy2, done2}, 0);
`ifdef MEM_DMA_READER_CHECKSUM_EN
        check({tag, "_csum"}, {csum1, csum2}, 0);
`endif
    endtask

    task automatic xfer(input string tag, input int b, input int l,
                        input bit rnd, input bit lat);
        int se, fv1, fv2, dn1, dn2, dc1, dc2, en_cnt, v_cnt, it;
        fv1 = -1; fv2 = -1; dn1 = -1; dn2 = -1;
        dc1 = 0; dc2 = 0; en_cnt = 0; v_cnt = 0; it = 0;
        push_exp(b, l);
        @(negedge clk);
        start = 1;
        base = 11'(b);
        len = 12'(l);
        @(posedge clk);
        #1;
        start = 0;
        se = cyc;
        while ((dn1 < 0 || dn2 < 0) && it < 300) begin
            if (bus1.out_valid && fv1 < 0) fv1 = cyc;
            if (bus2.out_valid && fv2 < 0) fv2 = cyc;
            if (done1) begin dc1++; if (dn1 < 0) dn1 = cyc; end
            if (done2) begin dc2++; if (dn2 < 0) dn2 = cyc; end
            if (bus1.ram_en_r || bus2.ram_en_r) en_cnt++;
            if (bus1.out_valid || bus2.out_valid) v_cnt++;
            if (rnd && it == 3) begin
                check({tag, "_busy_mid"}, {busy1, busy2}, 2'b11);
                start = 1;
                base = 11'h300;
                len = 12'd5;
            end else begin
                start = 0;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            it++;
        end
        start = 0;
        rdy = 1;
        check({tag, "_timeout"}, (dn1 >= 0 && dn2 >= 0), 1);
        if (lat) begin
            check({tag, "_lat1"}, fv1 - se, 2);
            check({tag, "_lat2"}, fv2 - se, 3);
        end
        if (!rnd && l > 0) begin
            check({tag, "_thru1"}, dn1 - fv1, l);
            check({tag, "_thru2"}, dn2 - fv2, l);
        end
        if (l == 0) begin
            check({tag, "_done_at"}, {dn1 - se, dn2 - se}, 0);
            check({tag, "_no_en"}, en_cnt, 0);
            check({tag, "_no_valid"}, v_cnt, 0);
        end else begin
            check({tag, "_done1"}, dn1 - last_acc[0], 1);
            check({tag, "_done2"}, dn2 - last_acc[1], 1);
        end
        check({tag, "_one_done"}, {dc1, dc2}, {32'd1, 32'd1});
        check({tag, "_busy_end"}, {busy1, busy2}, 0);
        check({tag, "_q_empty"}, q0.size() + q1.size(), 0);
    endtask

    initial begin
        int it;
        for (int i = 0; i < 2048; i++) ram[i] = exp_word(i);
        bus1.ram_dout = '0;
        bus2.ram_dout = '0;
        st2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        xfer("basic", 'h010, 4, 0, 1);
        xfer("wrap", 'h7FE, 4, 0, 0);
        xfer("len0", 'h055, 0, 0, 0);
        xfer("stall", 'h040, 16, 1, 0);

        // Abort after five accepted words of a ten-word transfer.
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        push_exp('h020, 10);
        @(negedge clk);
        start = 1;
        base = 11'h020;
        len = 12'd10;
        @(negedge clk);
        start = 0;
        it = 0;
        while (acc_cnt[0] < 5 && it < 100) begin
            @(posedge clk);
            #1;
            check("abort_no_done", {done1, done2}, 0);
            it++;
        end
        check("abort_timeout", acc_cnt[0], 5);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check_idle_zero("abort");
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post_rst_quiet", {done1, done2, bus1.out_valid,
                  bus2.out_valid}, 0);
        end
        xfer("fresh", 'h000, 2, 0, 1);

`ifdef MEM_DMA_READER_CHECKSUM_EN
        xfer("csum", 'h100, 3, 0, 0);
        check("csum_val", {csum1, csum2}, {8'h07, 8'h07});
        repeat (2) @(posedge clk);
        #1;
        check("csum_hold", {csum1, csum2}, {8'h07, 8'h07});
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
